// File: rtl/dcm_phase_sequencer_if.sv
// rtl/dcm_phase_sequencer_if.sv - command, status and DCM phase-shift signals of the sequencer
interface dcm_phase_sequencer_if #(
  parameter int PS_BITS = 9
);
  logic                      go_i;
  logic signed [PS_BITS-1:0] target_i;
  logic                      abort_i;
  logic                      dcm_rst_i;
  logic                      ps_en_o;
  logic                      ps_incdec_o;
  logic                      psdone_i;
  logic                      pslimit_i;
  logic signed [PS_BITS-1:0] phase_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      err_o;
  logic [1:0]                err_code_o;

  modport slave (
    input  go_i, target_i, abort_i, dcm_rst_i, psdone_i, pslimit_i,
    output ps_en_o, ps_incdec_o, phase_o, busy_o, done_o, err_o, err_code_o
  );

  modport master (
    output go_i, target_i, abort_i, dcm_rst_i, psdone_i, pslimit_i,
    input  ps_en_o, ps_incdec_o, phase_o, busy_o, done_o, err_o, err_code_o
  );
endinterface

// File: rtl/dcm_phase_sequencer.sv
// rtl/dcm_phase_sequencer.sv - walks the DCM dynamic phase shift to a signed target one tap at a time
module dcm_phase_sequencer #(
  parameter int PS_BITS   = 9,
  parameter int MAX_PHASE = 255,
  parameter int TIMEOUT   = 255,
  parameter int SETTLE    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcm_phase_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic signed [PS_BITS-1:0] MAX_P = PS_BITS'(MAX_PHASE);
  localparam logic signed [PS_BITS-1:0] NEG_P = PS_BITS'(-MAX_PHASE);

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_STEP, S_WAIT, S_SETTLE, S_FIN
  } state_t;

  state_t                    state_q;
  logic signed [PS_BITS-1:0] phase_q;
  logic signed [PS_BITS-1:0] target_q;
  logic signed [PS_BITS-1:0] target_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      ps_en_q;
  logic                      incdec_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic [1:0]                err_code_q;
  logic                      abort_pend_q;

  always_comb begin
    target_d = bus.target_i;
    if (bus.target_i > MAX_P) begin
      target_d = MAX_P;
    end else if (bus.target_i < NEG_P) begin
      target_d = NEG_P;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      ps_en_q      <= 1'b0;
      incdec_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      abort_pend_q <= 1'b0;
    end else begin
      ps_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.dcm_rst_i) begin
        // DCM phase is back at zero; error status is deliberately left alone
        state_q      <= S_IDLE;
        phase_q      <= '0;
        target_q     <= '0;
        abort_pend_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        if (bus.abort_i && (state_q inside {S_CMP, S_STEP, S_WAIT, S_SETTLE})) begin
          abort_pend_q <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (bus.go_i && !bus.abort_i) begin
              target_q     <= target_d;
              err_q        <= 1'b0;
              err_code_q   <= 2'b00;
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= S_CMP;
            end
          end
          S_CMP: begin
            if (abort_pend_q) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b11;
              done_q     <= 1'b1;
              state_q    <= S_FIN;
            end else if (target_q == phase_q) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              incdec_q <= (target_q > phase_q);
              ps_en_q  <= 1'b1;
              state_q  <= S_STEP;
            end
          end
          S_STEP: begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.psdone_i) begin
              if (bus.pslimit_i) begin
                err_q      <= 1'b1;
                err_code_q <= 2'b01;
                done_q     <= 1'b1;
                state_q    <= S_FIN;
              end else begin
                phase_q <= incdec_q ? phase_q + PS_BITS'(1) : phase_q - PS_BITS'(1);
                cnt_q   <= '0;
                state_q <= (SETTLE == 0) ? S_CMP : S_SETTLE;
              end
            end else if (cnt_q == TO_LAST) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
              done_q     <= 1'b1;
              state_q    <= S_FIN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (cnt_q == ST_LAST) begin
              state_q <= S_CMP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_FIN: begin
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ps_en_o     = ps_en_q;
  assign bus.ps_incdec_o = incdec_q;
  assign bus.phase_o     = phase_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.err_code_o  = err_code_q;

endmodule

// File: tb/tb_dcm_phase_sequencer.sv
// tb/tb_dcm_phase_sequencer.sv - directed vectors and corner sequences for dcm_phase_sequencer
module tb_dcm_phase_sequencer;

  localparam int PSB = 10;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  dcm_phase_sequencer_if #(.PS_BITS(PSB)) bus ();

  dcm_phase_sequencer #(.PS_BITS(PSB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int target;
    int lat;
    bit never;
    int limit;
    int abort_step;
    bit pre_rst;
    bit dir;
    int exp_phase;
    int exp_code;
    int exp_err;
    int exp_pulses;
    int exp_fd;
  } vec_t;

  vec_t vecs[7];

  int nchk = 0;
  int nerr = 0;

  int mdl_lat = 10, mdl_limit = 9999, mdl_abort_step = 0, mdl_phase = 0;
  bit mdl_never = 1'b0, exp_dir = 1'b1, dcm_inc = 1'b0;
  int dcm_cnt = 0, abort_arm = 0;
  int npulse, ndone, bad_dir, overlap, min_gap, first_cyc, last_cyc, done_cyc, go_cyc;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lo);
    nchk++;
    if (act < lo) begin
      nerr++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, lo);
    end
  endtask

  task automatic clr_stats();
    npulse = 0; ndone = 0; bad_dir = 0; overlap = 0;
    min_gap = 1000000; first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_go(input int tgt);
    @(posedge clk); #1;
    bus.go_i = 1'b1; bus.target_i = PSB'(tgt); go_cyc = cyc;
    @(posedge clk); #1;
    bus.go_i = 1'b0;
  endtask

  task automatic pulse_dcm_rst();
    @(posedge clk); #1;
    bus.dcm_rst_i = 1'b1;
    @(posedge clk); #1;
    bus.dcm_rst_i = 1'b0;
    mdl_phase = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && ndone == 0; i++) @(posedge clk);
  endtask

  // DCM model: psdone lat cycles after each PSEN, optional limit, optional abort injection
  initial begin
    bus.psdone_i  = 1'b0;
    bus.pslimit_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.psdone_i  = 1'b0;
      bus.pslimit_i = 1'b0;
      if (abort_arm == 1) begin
        bus.abort_i = 1'b1; abort_arm = 2;
      end else if (abort_arm == 2) begin
        bus.abort_i = 1'b0; abort_arm = 0;
      end
      if (dcm_cnt > 0) begin
        dcm_cnt--;
        if (dcm_cnt == 0 && !mdl_never) begin
          bus.psdone_i = 1'b1;
          if (dcm_inc && mdl_phase == mdl_limit) bus.pslimit_i = 1'b1;
          else mdl_phase += dcm_inc ? 1 : -1;
        end
      end
      if (bus.ps_en_o) begin
        if (dcm_cnt > 0) overlap++;
        npulse++;
        if (bus.ps_incdec_o != exp_dir) bad_dir++;
        if (npulse == 1) first_cyc = cyc;
        else if (cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
        last_cyc = cyc;
        dcm_cnt = mdl_lat;
        dcm_inc = bus.ps_incdec_o;
        if (npulse == mdl_abort_step) abort_arm = 1;
      end
      if (bus.done_o) begin
        ndone++; done_cyc = cyc;
      end
    end
  end

  initial begin
    vecs[0] = '{5,    10, 1'b0, 9999, 0, 1'b0, 1'b1,    5, 0, 0,   5,  -1};
    vecs[1] = '{-3,   10, 1'b0, 9999, 0, 1'b0, 1'b0,   -3, 0, 0,   8,  -1};
    vecs[2] = '{400,  10, 1'b0,  100, 0, 1'b0, 1'b1,  100, 1, 1, 104,  -1};
    vecs[3] = '{400,   1, 1'b0, 9999, 0, 1'b0, 1'b1,  255, 0, 0, 155,  -1};
    vecs[4] = '{-300,  1, 1'b0, 9999, 0, 1'b0, 1'b0, -255, 0, 0, 510,  -1};
    vecs[5] = '{10,   10, 1'b0, 9999, 3, 1'b1, 1'b1,    3, 3, 1,   3,  -1};
    vecs[6] = '{7,    10, 1'b1, 9999, 0, 1'b0, 1'b1,    3, 2, 1,   1, 256};

    rst = 1'b1;
    bus.go_i = 1'b0; bus.target_i = '0; bus.abort_i = 1'b0; bus.dcm_rst_i = 1'b0;
    clr_stats();
    #12;
    chk("rst ps_en", int'(bus.ps_en_o), 0);
    chk("rst incdec", int'(bus.ps_incdec_o), 0);
    chk("rst busy", int'(bus.busy_o), 0);
    chk("rst done", int'(bus.done_o), 0);
    chk("rst err", int'(bus.err_o), 0);
    chk("rst phase", int'(bus.phase_o), 0);
    chk("rst err_code", int'(bus.err_code_o), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 7; r++) begin
      if (vecs[r].pre_rst) pulse_dcm_rst();
      mdl_lat = vecs[r].lat; mdl_never = vecs[r].never; mdl_limit = vecs[r].limit;
      mdl_abort_step = vecs[r].abort_step; exp_dir = vecs[r].dir;
      clr_stats();
      pulse_go(vecs[r].target);
      wait_done(8000);
      repeat (40) @(posedge clk);
      #1;
      chk($sformatf("row%0d phase", r), int'(bus.phase_o), vecs[r].exp_phase);
      chk($sformatf("row%0d err_code", r), int'(bus.err_code_o), vecs[r].exp_code);
      chk($sformatf("row%0d err", r), int'(bus.err_o), vecs[r].exp_err);
      chk($sformatf("row%0d done count", r), ndone, 1);
      chk($sformatf("row%0d pulses", r), npulse, vecs[r].exp_pulses);
      chk($sformatf("row%0d wrong dir", r), bad_dir, 0);
      chk($sformatf("row%0d overlap", r), overlap, 0);
      chk($sformatf("row%0d busy", r), int'(bus.busy_o), 0);
      chk($sformatf("row%0d go->psen", r), first_cyc - go_cyc, 2);
      if (vecs[r].exp_pulses >= 2)
        chk_ge($sformatf("row%0d step gap", r), min_gap, 1 + vecs[r].lat + 3);
      if (vecs[r].exp_fd >= 0)
        chk($sformatf("row%0d psen->done", r), done_cyc - first_cyc, vecs[r].exp_fd);
    end

    // dcm_rst while idle keeps the timeout error status
    pulse_dcm_rst();
    #1;
    chk("idle dcm_rst phase", int'(bus.phase_o), 0);
    chk("idle dcm_rst err", int'(bus.err_o), 1);
    chk("idle dcm_rst err_code", int'(bus.err_code_o), 2);

    // go while busy is ignored
    mdl_lat = 2; mdl_never = 1'b0; mdl_limit = 9999; mdl_abort_step = 0; exp_dir = 1'b1;
    clr_stats();
    pulse_go(6);
    repeat (5) @(posedge clk);
    #1;
    bus.go_i = 1'b1; bus.target_i = PSB'(-50);
    @(posedge clk); #1;
    bus.go_i = 1'b0;
    wait_done(2000);
    repeat (20) @(posedge clk);
    #1;
    chk("busy go phase", int'(bus.phase_o), 6);
    chk("busy go pulses", npulse, 6);
    chk("busy go done count", ndone, 1);
    chk("busy go err_code", int'(bus.err_code_o), 0);

    // target equal to phase
    clr_stats();
    pulse_go(6);
    wait_done(100);
    repeat (10) @(posedge clk);
    #1;
    chk("same go->done", done_cyc - go_cyc, 2);
    chk("same pulses", npulse, 0);
    chk("same done count", ndone, 1);

    // abort and go together in IDLE: go dropped
    clr_stats();
    @(posedge clk); #1;
    bus.go_i = 1'b1; bus.abort_i = 1'b1; bus.target_i = PSB'(-20);
    @(posedge clk); #1;
    bus.go_i = 1'b0; bus.abort_i = 1'b0;
    chk("abort+go busy", int'(bus.busy_o), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort+go done count", ndone, 0);
    chk("abort+go pulses", npulse, 0);
    chk("abort+go phase", int'(bus.phase_o), 6);

    // dcm_rst mid-move
    clr_stats();
    pulse_go(20);
    for (int i = 0; i < 500 && npulse < 2; i++) @(posedge clk);
    chk("midrst pulses before", npulse, 2);
    @(posedge clk); #1;
    bus.dcm_rst_i = 1'b1;
    @(posedge clk); #1;
    bus.dcm_rst_i = 1'b0;
    mdl_phase = 0;
    chk("midrst phase", int'(bus.phase_o), 0);
    chk("midrst busy", int'(bus.busy_o), 0);
    chk("midrst ps_en", int'(bus.ps_en_o), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("midrst done count", ndone, 0);
    chk("midrst phase later", int'(bus.phase_o), 0);
    chk("midrst busy later", int'(bus.busy_o), 0);
    chk("midrst err", int'(bus.err_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
